// File: rtl/clock_monitor.sv
// Receiving-end checker for a divided clock: measures each high/low half-period in clk_sys cycles,
// declares lock after a run of in-tolerance halves and reports wrong-period and stuck-clock faults.
module clock_monitor #(
    parameter int EXP_HALF    = 5,
    parameter int TOL         = 0,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 32,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             clk_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] last_high,
    output logic [CNT_W-1:0] last_low,
    output logic             locked,
    output logic             stuck,
    output logic             err_pulse,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int GOOD_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam logic [GOOD_W-1:0]       GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [GOOD_W-1:0]       GOOD_ONE  = GOOD_W'(1);
    localparam logic [CNT_W-1:0]        CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]        TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic signed [CNT_W+1:0] GOOD_LO   = (CNT_W+2)'(EXP_HALF - TOL);
    localparam logic signed [CNT_W+1:0] GOOD_HI   = (CNT_W+2)'(EXP_HALF + TOL);

    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    hist_q;
    logic                    synced;
    logic                    edge_det;

    state_t                  state_q, state_d;
    logic [GOOD_W-1:0]       good_q, good_d;
    logic [CNT_W-1:0]        half_q, half_d;
    logic [CNT_W-1:0]        meas;
    logic signed [CNT_W+1:0] meas_s;
    logic                    good_half;
    logic                    timeout;
    logic [CNT_W-1:0]        last_high_d, last_low_d;
    logic                    stuck_d, err_d;
    logic [7:0]              err_count_d;

    // clk_in is asynchronous: resynchronize, then compare against one history flop
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q[0] <= clk_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= synced;
        end
    end

    assign synced   = sync_q[SYNC_STAGES-1];
    assign edge_det = synced ^ hist_q;

    // meas counts the current cycle too, so it equals the spacing between consecutive edges
    assign meas      = (half_q == CNT_MAX) ? CNT_MAX : half_q + CNT_ONE;
    assign meas_s    = $signed({2'b00, meas});
    assign good_half = (meas_s >= GOOD_LO) && (meas_s <= GOOD_HI);
    assign timeout   = (state_q != IDLE) && !edge_det && (meas == TIMEOUT_C);

    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        half_d      = meas;
        last_high_d = last_high;
        last_low_d  = last_low;
        stuck_d     = stuck;
        err_d       = 1'b0;

        if (edge_det) begin
            half_d = '0;
            if (state_q == IDLE) begin
                state_d = ACQUIRE;
                good_d  = '0;
                stuck_d = 1'b0;
            end else begin
                if (synced) begin
                    last_low_d = meas;
                end else begin
                    last_high_d = meas;
                end
                if (!good_half) begin
                    err_d   = 1'b1;
                    state_d = ACQUIRE;
                    good_d  = '0;
                end else if (state_q == ACQUIRE) begin
                    if (good_q == GOOD_LAST) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + GOOD_ONE;
                    end
                end
            end
        end else if (timeout) begin
            state_d = IDLE;
            good_d  = '0;
            stuck_d = 1'b1;
            err_d   = 1'b1;
        end

        err_count_d = err_count;
        if (err_d && (err_count != 8'hFF)) begin
            err_count_d = err_count + 8'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= IDLE;
            good_q     <= '0;
            half_q     <= '0;
            last_high  <= '0;
            last_low   <= '0;
            stuck      <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            half_q     <= half_d;
            last_high  <= last_high_d;
            last_low   <= last_low_d;
            stuck      <= stuck_d;
            err_pulse  <= err_d;
            err_count  <= err_count_d;
            rise_pulse <= edge_det & synced;
            fall_pulse <= edge_det & ~synced;
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: two instances (TOL=0 and TOL=1) share clk_in and are checked every cycle
// against a timestamp-based reference model, plus directed checks of the key scenarios.
module tb_clock_monitor;

    localparam int S     = 2;
    localparam int EXP   = 5;
    localparam int LOCKC = 4;
    localparam int TMO   = 32;

    logic clk_sys = 1'b0;
    logic rst;
    logic clk_in;

    logic       rise_p[2];
    logic       fall_p[2];
    logic       locked_o[2];
    logic       stuck_o[2];
    logic       err_p[2];
    logic [7:0] last_h[2];
    logic [7:0] last_l[2];
    logic [7:0] err_c[2];

    int n_cmp  = 0;
    int n_fail = 0;
    bit saw_lock;

    int m_mode[2];
    int m_run[2];
    int m_since[2];
    int m_lh[2];
    int m_ll[2];
    int m_ec[2];
    bit m_stuck[2];
    bit m_rise[2];
    bit m_fall[2];
    bit m_err[2];
    logic samp[$];
    logic cur_lvl, prev_lvl;

    always #5 clk_sys = ~clk_sys;

    clock_monitor #(.EXP_HALF(EXP), .TOL(0), .LOCK_COUNT(LOCKC), .TIMEOUT(TMO),
                    .CNT_W(8), .SYNC_STAGES(S)) dut0 (
        .clk_sys(clk_sys), .rst(rst), .clk_in(clk_in),
        .rise_pulse(rise_p[0]), .fall_pulse(fall_p[0]),
        .last_high(last_h[0]), .last_low(last_l[0]),
        .locked(locked_o[0]), .stuck(stuck_o[0]),
        .err_pulse(err_p[0]), .err_count(err_c[0])
    );

    clock_monitor #(.EXP_HALF(EXP), .TOL(1), .LOCK_COUNT(LOCKC), .TIMEOUT(TMO),
                    .CNT_W(8), .SYNC_STAGES(S)) dut1 (
        .clk_sys(clk_sys), .rst(rst), .clk_in(clk_in),
        .rise_pulse(rise_p[1]), .fall_pulse(fall_p[1]),
        .last_high(last_h[1]), .last_low(last_l[1]),
        .locked(locked_o[1]), .stuck(stuck_o[1]),
        .err_pulse(err_p[1]), .err_count(err_c[1])
    );

    // Model view: an edge shows up S+1 samples late; meas is the cycle distance since the previous event
    task automatic modelStep(input int k, input logic lvl, input bit edge_seen, input int tol);
        m_rise[k] = 1'b0;
        m_fall[k] = 1'b0;
        m_err[k]  = 1'b0;
        if (m_since[k] < 255) m_since[k]++;
        if (edge_seen) begin
            m_rise[k] = lvl;
            m_fall[k] = !lvl;
            if (m_mode[k] == 0) begin
                m_mode[k]  = 1;
                m_run[k]   = 0;
                m_stuck[k] = 1'b0;
            end else begin
                if (lvl) m_ll[k] = m_since[k];
                else     m_lh[k] = m_since[k];
                if (m_since[k] >= EXP - tol && m_since[k] <= EXP + tol) begin
                    if (m_mode[k] == 1) begin
                        m_run[k]++;
                        if (m_run[k] == LOCKC) m_mode[k] = 2;
                    end
                end else begin
                    m_err[k]  = 1'b1;
                    m_mode[k] = 1;
                    m_run[k]  = 0;
                end
            end
            m_since[k] = 0;
        end else if (m_mode[k] != 0 && m_since[k] == TMO) begin
            m_mode[k]  = 0;
            m_stuck[k] = 1'b1;
            m_err[k]   = 1'b1;
        end
        if (m_err[k] && m_ec[k] < 255) m_ec[k]++;
    endtask

    always @(posedge clk_sys) begin
        if (rst) begin
            samp.delete();
            for (int i = 0; i < S + 2; i++) samp.push_back(1'b0);
            for (int k = 0; k < 2; k++) begin
                m_mode[k] = 0; m_run[k] = 0; m_since[k] = 0; m_lh[k] = 0; m_ll[k] = 0;
                m_ec[k] = 0; m_stuck[k] = 1'b0; m_rise[k] = 1'b0; m_fall[k] = 1'b0; m_err[k] = 1'b0;
            end
        end else begin
            samp.push_back(clk_in);
            if (samp.size() > S + 3) samp.delete(0);
            cur_lvl  = samp[samp.size() - 1 - S];
            prev_lvl = samp[samp.size() - 2 - S];
            modelStep(0, cur_lvl, cur_lvl != prev_lvl, 0);
            modelStep(1, cur_lvl, cur_lvl != prev_lvl, 1);
        end
    end

    task automatic compare(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s[%0d]: observed %0d, expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic checkOutput();
        for (int k = 0; k < 2; k++) begin
            compare("rise_pulse", k, 32'(rise_p[k]), 32'(m_rise[k]));
            compare("fall_pulse", k, 32'(fall_p[k]), 32'(m_fall[k]));
            compare("last_high", k, 32'(last_h[k]), 32'(m_lh[k]));
            compare("last_low", k, 32'(last_l[k]), 32'(m_ll[k]));
            compare("locked", k, 32'(locked_o[k]), 32'(m_mode[k] == 2));
            compare("stuck", k, 32'(stuck_o[k]), 32'(m_stuck[k]));
            compare("err_pulse", k, 32'(err_p[k]), 32'(m_err[k]));
            compare("err_count", k, 32'(err_c[k]), 32'(m_ec[k]));
            if (locked_o[k]) saw_lock = 1'b1;
        end
    endtask

    // Holds clk_in at lvl for n cycles; reports first strobe index and err_pulse activity of instance 0
    task automatic applyStimulus(input logic lvl, input int n, output int strobe_at,
                                 output int errs, output int err_at);
        strobe_at = -1;
        errs      = 0;
        err_at    = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys);
            checkOutput();
            if (strobe_at < 0 && (rise_p[0] || fall_p[0])) strobe_at = i;
            if (err_p[0]) begin
                errs++;
                if (err_at < 0) err_at = i;
            end
            if (i == 0) clk_in = lvl;
        end
    endtask

    task automatic doReset();
        @(negedge clk_sys);
        checkOutput();
        rst    = 1'b1;
        clk_in = 1'b0;
        @(negedge clk_sys);
        checkOutput();
        for (int k = 0; k < 2; k++) begin
            compare("rst_outputs", k,
                    32'({rise_p[k], fall_p[k], locked_o[k], stuck_o[k], err_p[k]}), 32'd0);
            compare("rst_counts", k, {8'd0, last_h[k], last_l[k], err_c[k]}, 32'd0);
        end
        rst = 1'b0;
    endtask

    initial begin
        int s, e, ea, len, errsum;
        logic lvl;
        rst    = 1'b1;
        clk_in = 1'b0;
        $display("[TB] reset");
        doReset();

        $display("[TB] lock at nominal period");
        applyStimulus(1'b0, 8, s, e, ea);
        applyStimulus(1'b1, 5, s, e, ea);
        compare("strobe_latency", 0, 32'(s), 32'd3);
        applyStimulus(1'b0, 5, s, e, ea);
        applyStimulus(1'b1, 5, s, e, ea);
        applyStimulus(1'b0, 5, s, e, ea);
        compare("locked_before_5th", 0, 32'(locked_o[0]), 32'd0);
        applyStimulus(1'b1, 5, s, e, ea);
        compare("locked_at_5th", 0, 32'(locked_o[0]), 32'd1);
        compare("fall_latency", 0, 32'(s), 32'd3);
        applyStimulus(1'b0, 7, s, e, ea);
        compare("t1_last_high", 0, 32'(last_h[0]), 32'd5);
        compare("t1_last_low", 0, 32'(last_l[0]), 32'd5);
        compare("t1_err_count", 0, 32'(err_c[0]), 32'd0);

        $display("[TB] long low half while locked");
        applyStimulus(1'b1, 5, s, e, ea);
        compare("t2_err_cycles", 0, 32'(e), 32'd1);
        compare("t2_err_count", 0, 32'(err_c[0]), 32'd1);
        compare("t2_last_low", 0, 32'(last_l[0]), 32'd7);
        compare("t2_locked", 0, 32'(locked_o[0]), 32'd0);
        applyStimulus(1'b0, 5, s, e, ea);
        applyStimulus(1'b1, 5, s, e, ea);
        applyStimulus(1'b0, 5, s, e, ea);
        compare("t2_not_yet", 0, 32'(locked_o[0]), 32'd0);
        applyStimulus(1'b1, 5, s, e, ea);
        compare("t2_relock", 0, 32'(locked_o[0]), 32'd1);

        $display("[TB] stuck clock");
        applyStimulus(1'b0, 40, s, e, ea);
        compare("t3_stuck", 0, 32'(stuck_o[0]), 32'd1);
        compare("t3_locked", 0, 32'(locked_o[0]), 32'd0);
        compare("t3_err_count", 0, 32'(err_c[0]), 32'd2);
        compare("t3_err_cycles", 0, 32'(e), 32'd1);
        compare("t3_timeout_delay", 0, 32'(ea - s), 32'd32);
        applyStimulus(1'b1, 5, s, e, ea);
        compare("t3_stuck_clear", 0, 32'(stuck_o[0]), 32'd0);
        compare("t3_no_store", 0, 32'(last_l[0]), 32'd5);
        compare("t3_acquiring", 0, 32'(locked_o[0]), 32'd0);
        applyStimulus(1'b0, 5, s, e, ea);
        applyStimulus(1'b1, 5, s, e, ea);
        applyStimulus(1'b0, 5, s, e, ea);
        applyStimulus(1'b1, 5, s, e, ea);
        compare("t3_relock", 0, 32'(locked_o[0]), 32'd1);

        $display("[TB] reset while locked");
        compare("t5_err_before", 0, 32'(err_c[0]), 32'd2);
        doReset();
        applyStimulus(1'b0, 3, s, e, ea);
        applyStimulus(1'b1, 5, s, e, ea);
        applyStimulus(1'b0, 5, s, e, ea);
        applyStimulus(1'b1, 5, s, e, ea);
        applyStimulus(1'b0, 5, s, e, ea);
        compare("t5_not_yet", 0, 32'(locked_o[0]), 32'd0);
        applyStimulus(1'b1, 5, s, e, ea);
        compare("t5_relock", 0, 32'(locked_o[0]), 32'd1);
        compare("t5_err_count", 0, 32'(err_c[0]), 32'd0);

        $display("[TB] tolerance of one cycle");
        doReset();
        applyStimulus(1'b0, 6, s, e, ea);
        applyStimulus(1'b1, 4, s, e, ea);
        applyStimulus(1'b0, 6, s, e, ea);
        applyStimulus(1'b1, 4, s, e, ea);
        applyStimulus(1'b0, 6, s, e, ea);
        compare("t6_not_yet", 1, 32'(locked_o[1]), 32'd0);
        applyStimulus(1'b1, 4, s, e, ea);
        compare("t6_locked", 1, 32'(locked_o[1]), 32'd1);
        compare("t6_no_errors", 1, 32'(err_c[1]), 32'd0);
        applyStimulus(1'b0, 7, s, e, ea);
        applyStimulus(1'b1, 5, s, e, ea);
        compare("t6_err_count", 1, 32'(err_c[1]), 32'd1);
        compare("t6_unlocked", 1, 32'(locked_o[1]), 32'd0);

        $display("[TB] fast clock, error counter saturation");
        saw_lock = 1'b0;
        errsum   = 0;
        lvl      = 1'b0;
        for (int h = 0; h < 300; h++) begin
            applyStimulus(lvl, 3, s, e, ea);
            if (h >= 290) errsum += e;
            lvl = ~lvl;
        end
        compare("t4_never_locked", 0, 32'(saw_lock), 32'd0);
        compare("t4_sat0", 0, 32'(err_c[0]), 32'd255);
        compare("t4_sat1", 1, 32'(err_c[1]), 32'd255);
        compare("t4_err_strobes", 0, 32'(errsum), 32'd10);

        $display("[TB] randomized half-periods");
        doReset();
        lvl = 1'b1;
        for (int h = 0; h < 120; h++) begin
            if ($urandom_range(0, 11) == 0) len = 40;
            else if ($urandom_range(0, 1) == 0) len = $urandom_range(4, 6);
            else len = $urandom_range(2, 9);
            applyStimulus(lvl, len, s, e, ea);
            lvl = ~lvl;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
